// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// request owners and the mm_len transfer-size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MM = 1'b1
    } owner_e;

    localparam logic [1:0] LEN_BYTE     = 2'b00;
    localparam logic [1:0] LEN_HALF     = 2'b01;
    localparam logic [1:0] LEN_WORD     = 2'b10;
    localparam logic [1:0] LEN_WORD_ALT = 2'b11;

    // Instruction fetches always move a full word.
    localparam logic [2:0] IF_BYTES = 3'd4;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE:               return 3'd1;
            LEN_HALF:               return 3'd2;
            LEN_WORD, LEN_WORD_ALT: return 3'd4;
            default:                return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and data requests onto an 8-bit synchronous RAM,
// moving 1/2/4 bytes per transaction, little-endian, one byte per cycle.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_a,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_is,
    input  logic        mm_req,
    input  logic        mm_wr,
    input  logic [31:0] mm_a,
    input  logic [1:0]  mm_len,
    input  logic [31:0] mm_wn,
    output logic        mm_done,
    output logic [31:0] mm_rn,
    input  logic [7:0]  ram_rn,
    output logic [7:0]  ram_wn,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAT = cnt_t'(RD_LAT);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [2:0]  n_q, n_d;
    cnt_t        cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;

    logic [31:0] ram_a_d, if_is_d, mm_rn_d;
    logic [7:0]  ram_wn_d;
    logic        ram_wr_d, if_done_d, mm_done_d;

    logic        if_go, abort;
    cnt_t        cnt_n, last_addr, rd_last;
    logic [1:0]  cap_idx, wr_idx;
    logic [31:0] rd_word;

    // An IF request is only taken when no data request competes and no flush is pending.
    assign if_go     = if_req && !if_flush && !mm_req;
    assign abort     = (owner_q == OWN_IF) && if_flush;
    assign cnt_n     = {1'b0, n_q};
    assign last_addr = cnt_n - cnt_t'(1);
    assign rd_last   = last_addr + LAT;
    assign cap_idx   = cnt_q[1:0] - LAT[1:0];
    assign wr_idx    = cnt_q[1:0] + 2'd1;

    // Byte arriving this cycle merged into the partially assembled word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rd_word                      = buf_q;
        rd_word[{cap_idx, 3'b000} +: 8] = ram_rn;
    end

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mm_req)     state_d = mm_wr ? WR : RD;
                else if (if_go) state_d = RD;
            end
            RD: begin
                if (abort)                 state_d = IDLE;
                else if (cnt_q == rd_last) state_d = DONE;
            end
            WR: begin
                if (cnt_q == last_addr) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the transaction context.
    always_comb begin
        ram_a_d   = ram_a;
        ram_wn_d  = ram_wn;
        ram_wr_d  = 1'b0;
        if_done_d = 1'b0;
        mm_done_d = 1'b0;
        if_is_d   = if_is;
        mm_rn_d   = mm_rn;
        owner_d   = owner_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        wdata_d   = wdata_q;
        buf_d     = buf_q;

        case (state_q)
            IDLE: begin
                if (mm_req) begin
                    owner_d = OWN_MM;
                    n_d     = len_bytes(mm_len);
                    wdata_d = mm_wn;
                    ram_a_d = mm_a;
                    cnt_d   = '0;
                    buf_d   = '0;
                    if (mm_wr) begin
                        ram_wr_d = 1'b1;
                        ram_wn_d = mm_wn[7:0];
                    end
                end else if (if_go) begin
                    owner_d = OWN_IF;
                    n_d     = IF_BYTES;
                    ram_a_d = if_a;
                    cnt_d   = '0;
                    buf_d   = '0;
                end
            end
            RD: begin
                if (!abort) begin
                    cnt_d = cnt_q + cnt_t'(1);
                    if (cnt_q < last_addr) ram_a_d = ram_a + 32'd1;
                    if (cnt_q >= LAT)      buf_d   = rd_word;
                    if (cnt_q == rd_last) begin
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_is_d   = rd_word;
                        end else begin
                            mm_done_d = 1'b1;
                            mm_rn_d   = rd_word;
                        end
                    end
                end
            end
            WR: begin
                if (cnt_q == last_addr) begin
                    mm_done_d = 1'b1;
                end else begin
                    ram_wr_d = 1'b1;
                    cnt_d    = cnt_q + cnt_t'(1);
                    ram_a_d  = ram_a + 32'd1;
                    ram_wn_d = wdata_q[{wr_idx, 3'b000} +: 8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_a   <= '0;
            ram_wn  <= '0;
            ram_wr  <= 1'b0;
            if_done <= 1'b0;
            mm_done <= 1'b0;
            if_is   <= '0;
            mm_rn   <= '0;
            owner_q <= OWN_IF;
            n_q     <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            ram_a   <= ram_a_d;
            ram_wn  <= ram_wn_d;
            ram_wr  <= ram_wr_d;
            if_done <= if_done_d;
            mm_done <= mm_done_d;
            if_is   <= if_is_d;
            mm_rn   <= mm_rn_d;
            owner_q <= owner_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference model predicts every
// completion and every RAM write; monitors compare as the DUT presents them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_a, if_is;
    logic        mm_req, mm_wr, mm_done;
    logic [31:0] mm_a, mm_wn, mm_rn;
    logic [1:0]  mm_len;
    logic [7:0]  ram_rn, ram_wn;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_a(if_a), .if_flush(if_flush),
        .if_done(if_done), .if_is(if_is),
        .mm_req(mm_req), .mm_wr(mm_wr), .mm_a(mm_a), .mm_len(mm_len),
        .mm_wn(mm_wn), .mm_done(mm_done), .mm_rn(mm_rn),
        .ram_rn(ram_rn), .ram_wn(ram_wn), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_if;
        bit          is_store;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [39:0] exp_wr[$];
    logic [7:0]  ram_model [logic [31:0]];
    logic [7:0]  ref_mem   [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_read(input logic [31:0] a);
        return ram_model.exists(a) ? ram_model[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_a"},   ram_a,   0);
        check({tag, "_ram_wn"},  ram_wn,  0);
        check({tag, "_ram_wr"},  ram_wr,  0);
        check({tag, "_if_done"}, if_done, 0);
        check({tag, "_mm_done"}, mm_done, 0);
        check({tag, "_if_is"},   if_is,   0);
        check({tag, "_mm_rn"},   mm_rn,   0);
    endtask

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wr) ram_model[ram_a] = ram_wn;
        ram_rn <= ram_read(ram_a);
    end

    // Monitor: every RAM write strobe and every done pulse is matched against the queues.
    resp_t       mon_r;
    logic [39:0] mon_w;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr) begin
                if (exp_wr.size() == 0) flag("unexpected_ram_write");
                else begin
                    mon_w = exp_wr.pop_front();
                    check("ram_write", {ram_a, ram_wn}, mon_w);
                end
            end
            if (if_done && mm_done) flag("both_done_same_cycle");
            else if (if_done || mm_done) begin
                if (exp_q.size() == 0) flag("unexpected_done");
                else begin
                    mon_r = exp_q.pop_front();
                    check("done_owner", if_done, mon_r.is_if);
                    if (!mon_r.is_store)
                        check("read_data", mon_r.is_if ? if_is : mm_rn, mon_r.data);
                end
            end
        end
    end

    // Issue one transaction from an IDLE negedge, predict its outcome, wait for completion.
    task automatic run_xact(input bit is_if, input bit wr, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit flush_mid);
        int          n, lat, exp_lat;
        logic [31:0] d, ea;
        resp_t       r;
        bit          got;
        n = is_if ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
        d = '0;
        for (int i = 0; i < n; i++) begin
            ea = addr + 32'(i);
            if (wr) begin
                exp_wr.push_back({ea, wdata[8*i +: 8]});
                ref_mem[ea] = wdata[8*i +: 8];
            end else begin
                d[8*i +: 8] = ref_read(ea);
            end
        end
        r.is_if = is_if; r.is_store = wr; r.data = d;
        exp_q.push_back(r);
        if (is_if) begin
            if_req = 1'b1; if_a = addr;
        end else begin
            mm_req = 1'b1; mm_wr = wr; mm_len = len; mm_a = addr; mm_wn = wdata;
        end
        exp_lat = wr ? n + 1 : n + 2;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if_flush = flush_mid && (lat == 2);
            if (!wr && lat <= n) begin
                ea = addr + 32'(lat) - 32'd1;
                check("read_addr", ram_a, ea);
                check("read_no_wr", ram_wr, 0);
            end
            got = is_if ? if_done : mm_done;
        end
        if_flush = 1'b0;
        check(is_if ? "fetch_latency" : (wr ? "store_latency" : "load_latency"), lat, exp_lat);
        if_req = 1'b0;
        mm_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!wr) check("hold_after_done", is_if ? if_is : mm_rn, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d_mm, d_if, a;
        resp_t       r;
        int          lat, kind;
        bit          got;

        rst = 1'b1;
        if_req = 0; if_a = 0; if_flush = 0;
        mm_req = 0; mm_wr = 0; mm_a = 0; mm_len = 0; mm_wn = 0;
        ram_model[32'd0] = 8'h13; ram_model[32'd1] = 8'h00;
        ram_model[32'd2] = 8'h50; ram_model[32'd3] = 8'h00;
        ref_mem[32'd0] = 8'h13; ref_mem[32'd1] = 8'h00;
        ref_mem[32'd2] = 8'h50; ref_mem[32'd3] = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Fetch of a known instruction word, then a word store.
        run_xact(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
        run_xact(1'b0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 1'b0);

        // Simultaneous requests: the data load is served first.
        d_mm = {24'h0, ref_read(32'h100)};
        d_if = {ref_read(32'hB), ref_read(32'hA), ref_read(32'h9), ref_read(32'h8)};
        r.is_if = 1'b0; r.is_store = 1'b0; r.data = d_mm; exp_q.push_back(r);
        r.is_if = 1'b1; r.is_store = 1'b0; r.data = d_if; exp_q.push_back(r);
        if_req = 1'b1; if_a = 32'h8;
        mm_req = 1'b1; mm_wr = 1'b0; mm_len = 2'b00; mm_a = 32'h100;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk); lat++; got = mm_done;
        end
        check("arb_mm_latency", lat, 3);
        mm_req = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk); lat++; got = if_done;
        end
        check("arb_if_latency", lat, 7);
        if_req = 1'b0;
        @(posedge clk); @(negedge clk);

        // Address wrap across 0xFFFFFFFF.
        run_xact(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 1'b0);
        run_xact(1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 1'b0);

        // Flush two cycles into a fetch aborts it; controller is idle on the next cycle.
        if_req = 1'b1; if_a = 32'h0;
        @(posedge clk); @(negedge clk); @(negedge clk);
        check("flush_point_addr", ram_a, 32'h1);
        if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        if_flush = 1'b0;
        check("flush_no_done", if_done, 0);
        run_xact(1'b0, 1'b1, 2'b01, 32'h130, $urandom, 1'b0);
        run_xact(1'b1, 1'b0, 2'b10, 32'h4, 32'h0, 1'b0);

        // Flush while idle holds off fetch acceptance for that edge.
        if_req = 1'b1; if_a = 32'h10; if_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        if_flush = 1'b0;
        run_xact(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);

        // Flush has no effect on a data load.
        run_xact(1'b0, 1'b0, 2'b11, 32'h102, 32'h0, 1'b1);

        // Reset while the third byte of a word store is on the bus.
        for (int i = 0; i < 3; i++) exp_wr.push_back({32'h120 + 32'(i), 8'(32'h11223344 >> (8*i))});
        ref_mem[32'h120] = 8'h44;
        ref_mem[32'h121] = 8'h33;
        mm_req = 1'b1; mm_wr = 1'b1; mm_len = 2'b10; mm_a = 32'h120; mm_wn = 32'h11223344;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("store_byte2_active", {ram_wr, ram_a}, {1'b1, 32'h122});
        #2 rst = 1'b1;
        mm_req = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("quiet_after_rst", {mm_done, if_done, ram_wr}, 0);
        end
        run_xact(1'b0, 1'b0, 2'b10, 32'h120, 32'h0, 1'b0);

        // Randomized mix of fetches, loads and stores.
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h100 + 32'($urandom_range(0, 63));
            run_xact(kind == 0, kind == 2, 2'($urandom_range(0, 3)), a, $urandom,
                     (kind != 0) && ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        check("resp_queue_empty", exp_q.size(), 0);
        check("write_queue_empty", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
